bus_arbiter_rr: RTL and testbench
=================================

BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter SIZE, default 32: width of each value, in bits.
REQ-002 SHALL have parameter STATION_COUNT, default 4: number of requesting stations, legal range 2..32.
REQ-003 SHALL have parameter BUS_COUNT, default 2: number of result buses, legal range 1..STATION_COUNT.
REQ-004 SHALL derive local STATION_INDEX_SIZE = $clog2(STATION_COUNT).
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clock  in  1  rising-edge clock.
REQ-007 reset_n  in  1  asynchronous active-low reset.
REQ-008 station_ready_flat  in  STATION_COUNT  bit i high: station i requests a bus.
REQ-009 station_value_flat  in  STATION_COUNT*SIZE  value of station i, at bits [i*SIZE +: SIZE].
REQ-010 station_granted_flat  out  STATION_COUNT  registered one-cycle acknowledge per station.
REQ-011 bus_asserted_flat  out  BUS_COUNT  registered bus-valid flags.
REQ-012 bus_source_flat  out  BUS_COUNT*STATION_INDEX_SIZE  registered winning station index per bus.
REQ-013 bus_value_flat  out  BUS_COUNT*SIZE  registered winning value per bus.

Function
REQ-014 On each rising edge, arbitration SHALL sample eligible requests: station_ready[i] high and station_granted[i] low.
REQ-015 Arbitration SHALL scan stations in rotation order, starting at the priority pointer ptr and wrapping modulo STATION_COUNT.
REQ-016 The k-th eligible station found (k < BUS_COUNT) SHALL be assigned bus k.
REQ-017 Any eligible stations beyond the first BUS_COUNT SHALL stay ungranted; their requests are retried on the next cycle.
REQ-018 For each assigned bus k, the edge SHALL register bus_asserted[k]=1, bus_source[k]=station index and bus_value[k]=station value.
REQ-019 Unassigned buses SHALL register bus_asserted=0, bus_source=0 and bus_value=0.
REQ-020 station_granted[i] SHALL be registered high on the same edge as its bus outputs, for exactly one cycle; latency is one cycle from request sample to grant.
REQ-021 A station SHALL hold ready and value stable until it sees station_granted high, and SHALL drop ready on the following edge; the eligibility mask of REQ-014 prevents a double grant in that cycle.
REQ-022 A station SHALL receive at most one bus per cycle.
REQ-023 ptr SHALL update to (last granted index + 1) mod STATION_COUNT, where "last" means last in rotation order; with no grants, ptr SHALL hold.
REQ-024 When all stations request continuously, any station SHALL be granted within ceil(STATION_COUNT/BUS_COUNT) cycles.
REQ-025 Stations requesting when ptr wraps from STATION_COUNT-1 to 0 SHALL be handled identically to any other position.

Reset
REQ-026 Asserting reset_n low SHALL immediately clear ptr, every bus_* output and station_granted, regardless of the clock.
REQ-027 A reset mid-operation SHALL discard in-flight grants; stations that are still requesting are re-arbitrated from ptr=0 after release.
REQ-028 The first arbitration SHALL occur on the first rising edge with reset_n high.

Configuration
REQ-029 The macro BUS_ARBITER_RR_ROTATE_EN, when defined, SHALL enable the rotating ptr behaviour of REQ-015 and REQ-023.
REQ-030 When BUS_ARBITER_RR_ROTATE_EN is undefined, ptr SHALL be fixed at 0, giving fixed lowest-index-first priority; REQ-024 is then waived, and all other requirements still hold.

Verification
REQ-031 Reset: drive reset_n=0 mid-cycle with requests pending -> all outputs 0 immediately; after release with STATION_COUNT=4 and ready=4'b1111, the first edge grants stations 0 and 1 on buses 0 and 1.
REQ-032 Rotation (ROTATE_EN, 4 stations, 2 buses): ready held at 4'b1111 with each grant honoured -> grant pairs {0,1}, then {2,3}, then {0,1}; bus_source matches each pair.
REQ-033 Wrap-around: ptr=3, ready=4'b1001 -> bus0 source=3, bus1 source=0, and ptr becomes 1.
REQ-034 Handshake: station 2 alone, value 0xDEADBEEF, ready still high in the grant cycle -> exactly one grant; bus0 carries 0xDEADBEEF for one cycle, and the next cycle shows bus_asserted=0.
REQ-035 Fixed priority (macro undefined): ready=4'b1100 every cycle, stations 2 and 3 re-requesting after each grant -> granted every other cycle; then ready=4'b1111 -> stations 0 and 1 always win.
REQ-036 Overflow (BUS_COUNT=1, 3 stations all requesting) -> exactly one grant per cycle, and no station waits more than 3 cycles.

Source files
------------

// File: rtl/bus_arbiter_rr_if.sv
// bus_arbiter_rr_if: station request/grant and result-bus bundle for bus_arbiter_rr
interface bus_arbiter_rr_if #(
  parameter int SIZE = 32,
  parameter int STATION_COUNT = 4,
  parameter int BUS_COUNT = 2
) ();
  localparam int STATION_INDEX_SIZE = $clog2(STATION_COUNT);
  logic [STATION_COUNT-1:0]                    station_ready_flat;
  logic [STATION_COUNT*SIZE-1:0]               station_value_flat;
  logic [STATION_COUNT-1:0]                    station_granted_flat;
  logic [BUS_COUNT-1:0]                        bus_asserted_flat;
  logic [BUS_COUNT*STATION_INDEX_SIZE-1:0]     bus_source_flat;
  logic [BUS_COUNT*SIZE-1:0]                   bus_value_flat;
  modport master (
    output station_ready_flat, station_value_flat,
    input  station_granted_flat, bus_asserted_flat, bus_source_flat, bus_value_flat
  );
  modport slave (
    input  station_ready_flat, station_value_flat,
    output station_granted_flat, bus_asserted_flat, bus_source_flat, bus_value_flat
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: assigns up to BUS_COUNT requesting stations per cycle to result buses.
// Define BUS_ARBITER_RR_ROTATE_EN for round-robin priority; otherwise lowest index wins.
module bus_arbiter_rr #(
  parameter int SIZE = 32,
  parameter int STATION_COUNT = 4,
  parameter int BUS_COUNT = 2
) (
  input logic           clock,
  input logic           reset_n,
  bus_arbiter_rr_if.slave bus
);
  localparam int STATION_INDEX_SIZE = $clog2(STATION_COUNT);
  logic [STATION_INDEX_SIZE-1:0]           ptr_q, ptr_d;
  logic [STATION_COUNT-1:0]                granted_q, granted_d, eligible;
  logic [BUS_COUNT-1:0]                    asserted_q, asserted_d;
  logic [BUS_COUNT*STATION_INDEX_SIZE-1:0] source_q, source_d;
  logic [BUS_COUNT*SIZE-1:0]               value_q, value_d;
  int idx, cnt;
  // a station granted last cycle may still show ready; mask it to avoid a double grant
  assign eligible = bus.station_ready_flat & ~granted_q;
  always_comb begin
    granted_d  = '0;
    asserted_d = '0;
    source_d   = '0;
    value_d    = '0;
`ifdef BUS_ARBITER_RR_ROTATE_EN
    ptr_d      = ptr_q;
`else
    ptr_d      = '0;
`endif
    idx        = 0;
    cnt        = 0;
    for (int o = 0; o < STATION_COUNT; o++) begin
      idx = int'(ptr_q) + o;
      idx = idx >= STATION_COUNT ? idx - STATION_COUNT : idx;
      if (eligible[idx] && cnt < BUS_COUNT) begin
        granted_d[idx] = 1'b1;
        asserted_d[cnt] = 1'b1;
        source_d[cnt*STATION_INDEX_SIZE +: STATION_INDEX_SIZE] = STATION_INDEX_SIZE'(idx);
        value_d[cnt*SIZE +: SIZE] = bus.station_value_flat[idx*SIZE +: SIZE];
`ifdef BUS_ARBITER_RR_ROTATE_EN
        ptr_d = idx == STATION_COUNT - 1 ? '0 : STATION_INDEX_SIZE'(idx + 1);
`endif
        cnt++;
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      granted_q  <= '0;
      asserted_q <= '0;
      source_q   <= '0;
      value_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      granted_q  <= granted_d;
      asserted_q <= asserted_d;
      source_q   <= source_d;
      value_q    <= value_d;
    end
  end
  assign bus.station_granted_flat = granted_q;
  assign bus.bus_asserted_flat    = asserted_q;
  assign bus.bus_source_flat      = source_q;
  assign bus.bus_value_flat       = value_q;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed and random checks of bus_arbiter_rr against a queue-based model.
module tb_bus_arbiter_rr;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;
  bus_arbiter_rr_if #(.SIZE(32), .STATION_COUNT(4), .BUS_COUNT(2)) i1 ();
  bus_arbiter_rr_if #(.SIZE(32), .STATION_COUNT(3), .BUS_COUNT(1)) i3 ();
  bus_arbiter_rr #(.SIZE(32), .STATION_COUNT(4), .BUS_COUNT(2)) dut1 (
    .clock(clock), .reset_n(reset_n), .bus(i1));
  bus_arbiter_rr #(.SIZE(32), .STATION_COUNT(3), .BUS_COUNT(1)) dut3 (
    .clock(clock), .reset_n(reset_n), .bus(i3));
  int n_checks = 0;
  int n_errors = 0;
  int p1, p3;
  logic [31:0]  g1, g3, e_as1, e_as3;
  logic [127:0] e_src1, e_val1, e_src3, e_val3;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // gather eligible stations in rotation order, first b of them win buses 0..b-1
  task automatic model(input int n, input int b, input logic [31:0] ready,
                       input logic [127:0] vals, input int ptr, input logic [31:0] gr,
                       output int nptr, output logic [31:0] ngr, output logic [31:0] as_,
                       output logic [127:0] src, output logic [127:0] val);
    int q[$];
    for (int o = 0; o < n; o++)
      if (ready[(ptr + o) % n] && !gr[(ptr + o) % n]) q.push_back((ptr + o) % n);
    ngr = '0; as_ = '0; src = '0; val = '0; nptr = ptr;
    for (int k = 0; k < b && k < q.size(); k++) begin
      ngr[q[k]] = 1'b1;
      as_[k] = 1'b1;
      src[k*2 +: 2] = 2'(q[k]);
      val[k*32 +: 32] = vals[q[k]*32 +: 32];
    end
`ifdef BUS_ARBITER_RR_ROTATE_EN
    if (q.size() > 0) nptr = (q[(b < q.size() ? b : q.size()) - 1] + 1) % n;
`endif
  endtask

  task automatic tick();
    @(posedge clock);
    model(4, 2, 32'(i1.station_ready_flat), 128'(i1.station_value_flat), p1, g1,
          p1, g1, e_as1, e_src1, e_val1);
    model(3, 1, 32'(i3.station_ready_flat), 128'(i3.station_value_flat), p3, g3,
          p3, g3, e_as3, e_src3, e_val3);
    #1;
    check("gr1", 128'(i1.station_granted_flat), 128'(g1[3:0]));
    check("as1", 128'(i1.bus_asserted_flat), 128'(e_as1[1:0]));
    check("src1", 128'(i1.bus_source_flat), 128'(e_src1[3:0]));
    check("val1", 128'(i1.bus_value_flat), 128'(e_val1[63:0]));
    check("gr3", 128'(i3.station_granted_flat), 128'(g3[2:0]));
    check("as3", 128'(i3.bus_asserted_flat), 128'(e_as3[0]));
    check("src3", 128'(i3.bus_source_flat), 128'(e_src3[1:0]));
    check("val3", 128'(i3.bus_value_flat), 128'(e_val3[31:0]));
  endtask

  // called 1 time unit after a rising edge; asserts reset mid-cycle
  task automatic do_reset();
    #3 reset_n = 1'b0;
    #1;
    check("rst_gr1", 128'(i1.station_granted_flat), 128'(0));
    check("rst_as1", 128'(i1.bus_asserted_flat), 128'(0));
    check("rst_src1", 128'(i1.bus_source_flat), 128'(0));
    check("rst_val1", 128'(i1.bus_value_flat), 128'(0));
    check("rst_gr3", 128'(i3.station_granted_flat), 128'(0));
    check("rst_as3", 128'(i3.bus_asserted_flat), 128'(0));
    p1 = 0; p3 = 0; g1 = '0; g3 = '0;
    #2 reset_n = 1'b1;
  endtask

  initial begin
`ifdef BUS_ARBITER_RR_ROTATE_EN
    int w3[3] = '{0, 0, 0};
`endif
    i1.station_ready_flat = '0;
    i1.station_value_flat = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    i3.station_ready_flat = '0;
    i3.station_value_flat = '0;
    p1 = 0; p3 = 0; g1 = '0; g3 = '0;
    @(posedge clock);
    #1;
    i1.station_ready_flat = 4'b1111;
    do_reset();
    tick();
    check("first_gr", 128'(i1.station_granted_flat), 128'(4'b0011));
    check("first_src", 128'(i1.bus_source_flat), 128'(4'b0100));
    i1.station_ready_flat = '0;
    do_reset();
    i1.station_value_flat[64 +: 32] = 32'hDEAD_BEEF;
    i1.station_ready_flat = 4'b0100;
    tick();
    check("hs_gr", 128'(i1.station_granted_flat), 128'(4'b0100));
    check("hs_val", 128'(i1.bus_value_flat[31:0]), 128'(32'hDEAD_BEEF));
    tick();
    check("hs_drop", 128'(i1.bus_asserted_flat), 128'(0));
    i1.station_ready_flat = '0;
`ifdef BUS_ARBITER_RR_ROTATE_EN
    do_reset();
    i1.station_ready_flat = 4'b1111;
    tick();
    check("rot_gr_a", 128'(i1.station_granted_flat), 128'(4'b0011));
    tick();
    check("rot_gr_b", 128'(i1.station_granted_flat), 128'(4'b1100));
    check("rot_src_b", 128'(i1.bus_source_flat), 128'(4'b1110));
    tick();
    check("rot_gr_c", 128'(i1.station_granted_flat), 128'(4'b0011));
    check("rot_src_c", 128'(i1.bus_source_flat), 128'(4'b0100));
    do_reset();
    i1.station_ready_flat = 4'b0100;
    tick();
    i1.station_ready_flat = 4'b1001;
    tick();
    check("wrap_src", 128'(i1.bus_source_flat), 128'(4'b0011));
    check("wrap_as", 128'(i1.bus_asserted_flat), 128'(2'b11));
    i1.station_ready_flat = 4'b1111;
    tick();
    check("wrap_ptr", 128'(i1.bus_source_flat), 128'(4'b1001));
`else
    do_reset();
    i1.station_ready_flat = 4'b1100;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fix_alt", 128'(i1.station_granted_flat), 128'(i % 2 == 0 ? 4'b1100 : 4'b0000));
    end
    i1.station_ready_flat = 4'b1111;
    tick();
    check("fix_low", 128'(i1.station_granted_flat), 128'(4'b0011));
    check("fix_src", 128'(i1.bus_source_flat[1:0]), 128'(0));
`endif
    i1.station_ready_flat = '0;
    do_reset();
    i3.station_value_flat = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    i3.station_ready_flat = 3'b111;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("ovf_one", 128'($countones(i3.station_granted_flat)), 128'(1));
`ifdef BUS_ARBITER_RR_ROTATE_EN
      for (int s = 0; s < 3; s++) begin
        w3[s] = i3.station_granted_flat[s] ? 0 : w3[s] + 1;
        check("ovf_wait", 128'(w3[s] < 3), 128'(1));
      end
`endif
    end
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      i1.station_ready_flat = 4'($urandom);
      i1.station_value_flat = {$urandom, $urandom, $urandom, $urandom};
      i3.station_ready_flat = 3'($urandom);
      i3.station_value_flat = {$urandom, $urandom, $urandom};
      tick();
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
